// File: rtl/pa_icache_sram_arb.sv
// pa_icache_sram_arb: single-port I-cache SRAM arbiter.
// Arbitrates a fetch read port and a refill write port onto one SRAM macro,
// with an anti-starvation counter for reads and an invalidate sweep that zeroes
// every address. Define PA_ICACHE_SRAM_INIT_EN to run the zero sweep out of
// reset (INIT state); without it, reset lands directly in RUN.
module pa_icache_sram_arb #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 37,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_mask,
    output logic                  wr_gnt,
    input  logic                  inv_req,
    output logic                  inv_done,
    output logic                  ctrl_busy,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_SWEEP
    } state_t;

`ifdef PA_ICACHE_SRAM_INIT_EN
    localparam state_t RESET_STATE = ST_INIT;
`else
    localparam state_t RESET_STATE = ST_RUN;
`endif

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  rd_vld_q, rd_vld_d;
    logic                  inv_done_q, inv_done_d;
    logic                  rd_first;

    // SRAM macro data comes straight through; consumers qualify it with rd_vld.
    assign rd_data  = sram_q;
    assign rd_vld   = rd_vld_q;
    assign inv_done = inv_done_q;

    // Next-state, arbitration and SRAM control decode.
    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        starve_d    = '0;
        inv_done_d  = 1'b0;
        rd_first    = 1'b0;
        rd_gnt      = 1'b0;
        wr_gnt      = 1'b0;
        ctrl_busy   = 1'b1;
        sram_cen    = 1'b1;
        sram_gwen   = 1'b1;
        sram_a      = '0;
        sram_d      = '0;
        sram_wen    = '1;

        case (state_q)
            ST_RUN: begin
                ctrl_busy = 1'b0;
                // A read that has been denied STARVE_LIMIT times in a row beats the refill.
                rd_first  = rd_req && (starve_q == STARVE_MAX);
                wr_gnt    = wr_req && !rd_first;
                rd_gnt    = rd_req && !wr_gnt;
                if (wr_gnt) begin
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_a    = wr_addr;
                    sram_d    = wr_data;
                    sram_wen  = ~wr_mask;
                end else if (rd_gnt) begin
                    sram_cen  = 1'b0;
                    sram_a    = rd_addr;
                end
                if (rd_req && !rd_gnt) begin
                    starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + STARVE_W'(1);
                end
                // The grant issued this cycle still completes; the sweep starts next cycle.
                if (inv_req) begin
                    state_d = ST_SWEEP;
                end
            end
            ST_INIT, ST_SWEEP: begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_a    = sweep_cnt_q;
                sram_d    = '0;
                sram_wen  = '0;
                if (sweep_cnt_q == '1) begin
                    state_d     = ST_RUN;
                    sweep_cnt_d = '0;
                    // Only an invalidate sweep reports completion; the power-on init does not.
                    inv_done_d  = (state_q == ST_SWEEP);
                end else begin
                    sweep_cnt_d = sweep_cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Reset must silence the macro even though the reset state may itself drive it.
        if (cpurst) begin
            rd_gnt    = 1'b0;
            wr_gnt    = 1'b0;
            sram_cen  = 1'b1;
            sram_gwen = 1'b1;
        end

        rd_vld_d = rd_gnt;
    end

    // State, counters and the registered status pulses.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order; blocking stays in always_comb.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q     <= RESET_STATE;
            sweep_cnt_q <= '0;
            starve_q    <= '0;
            rd_vld_q    <= 1'b0;
            inv_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            starve_q    <= starve_d;
            rd_vld_q    <= rd_vld_d;
            inv_done_q  <= inv_done_d;
        end
    end

endmodule

// File: tb/tb_pa_icache_sram_arb.sv
// tb_pa_icache_sram_arb: self-checking bench for pa_icache_sram_arb.
// A cycle-level reference model (plain integers: busy flag, sweep address,
// denial count) predicts every output; each test task compares inline.
// Honours PA_ICACHE_SRAM_INIT_EN so the same bench covers both builds.
module tb_pa_icache_sram_arb;

    localparam int AW    = 10;
    localparam int DW    = 37;
    localparam int LIMIT = 3;
    localparam int LAST  = (1 << AW) - 1;
`ifdef PA_ICACHE_SRAM_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    typedef struct packed {
        logic          rd_gnt;
        logic          wr_gnt;
        logic          rd_vld;
        logic          inv_done;
        logic          ctrl_busy;
        logic          cen;
        logic          gwen;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] wen;
        logic [DW-1:0] rdata;
    } obs_t;

    logic          clk = 1'b0;
    logic          cpurst = 1'b0;
    logic          rd_req = 1'b0, wr_req = 1'b0, inv_req = 1'b0;
    logic [AW-1:0] rd_addr = '0, wr_addr = '0;
    logic [DW-1:0] wr_data = '0, wr_mask = '0, sram_q = '0;
    logic          rd_gnt, rd_vld, wr_gnt, inv_done, ctrl_busy, sram_cen, sram_gwen;
    logic [DW-1:0] rd_data, sram_wen, sram_d;
    logic [AW-1:0] sram_a;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    bit m_busy, m_sweep, m_rd_vld, m_inv_done;
    int m_addr, m_denials;

    pa_icache_sram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .forever_cpuclk(clk), .cpurst(cpurst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_vld(rd_vld), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_gnt(wr_gnt),
        .inv_req(inv_req), .inv_done(inv_done), .ctrl_busy(ctrl_busy),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
        .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
    );

    initial forever #5 clk = ~clk;

    function automatic obs_t predict();
        obs_t e;
        bit   rd_prio;
        e = '0;
        e.rd_vld    = m_rd_vld;
        e.inv_done  = m_inv_done;
        e.ctrl_busy = m_busy;
        e.cen       = 1'b1;
        e.gwen      = 1'b1;
        if (m_rd_vld) e.rdata = sram_q;
        if (m_busy) begin
            e.cen  = 1'b0;
            e.gwen = 1'b0;
            e.a    = AW'(m_addr);
        end else begin
            rd_prio  = rd_req && (m_denials >= LIMIT);
            e.wr_gnt = wr_req && !rd_prio;
            e.rd_gnt = rd_req && !e.wr_gnt;
            if (e.wr_gnt) begin
                e.cen  = 1'b0;
                e.gwen = 1'b0;
                e.a    = wr_addr;
                e.d    = wr_data;
                e.wen  = ~wr_mask;
            end else if (e.rd_gnt) begin
                e.cen = 1'b0;
                e.a   = rd_addr;
            end
        end
        return e;
    endfunction

    // Observed outputs with fields the expectation leaves undefined zeroed.
    function automatic obs_t observe(input obs_t e);
        obs_t o;
        o = {rd_gnt, wr_gnt, rd_vld, inv_done, ctrl_busy, sram_cen, sram_gwen,
             sram_a, sram_d, sram_wen, rd_data};
        if (!e.rd_vld) o.rdata = '0;
        if (e.cen) begin
            o.a   = '0;
            o.d   = '0;
            o.wen = '0;
        end
        if (e.rd_gnt) begin
            o.d   = '0;
            o.wen = '0;
        end
        return o;
    endfunction

    task automatic model_advance(input obs_t e);
        m_rd_vld   = e.rd_gnt;
        m_inv_done = m_busy && m_sweep && (m_addr == LAST);
        if (m_busy) begin
            m_denials = 0;
            if (m_addr == LAST) begin
                m_busy = 1'b0;
                m_addr = 0;
            end else begin
                m_addr++;
            end
        end else begin
            if (rd_req && !e.rd_gnt) m_denials = (m_denials >= LIMIT) ? LIMIT : m_denials + 1;
            else m_denials = 0;
            if (inv_req) begin
                m_busy  = 1'b1;
                m_sweep = 1'b1;
                m_addr  = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_busy     = INIT_EN;
        m_sweep    = 1'b0;
        m_addr     = 0;
        m_denials  = 0;
        m_rd_vld   = 1'b0;
        m_inv_done = 1'b0;
    endtask

    // One clock: sample settled outputs, then let the edge advance DUT and model.
    task automatic do_cycle(output obs_t o, output obs_t e);
        #1;
        e = predict();
        o = observe(e);
        @(posedge clk);
        model_advance(e);
        @(negedge clk);
        cyc++;
    endtask

    task automatic randomize_ports();
        rd_req  = $urandom_range(0, 1);
        wr_req  = $urandom_range(0, 1);
        rd_addr = AW'($urandom);
        wr_addr = AW'($urandom);
        wr_data = {$urandom, $urandom};
        wr_mask = {$urandom, $urandom};
        sram_q  = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        obs_t o, e;
        cpurst  = 1'b1;
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({sram_cen, sram_gwen, rd_gnt, wr_gnt, rd_vld, inv_done} !== 6'b110000) begin
            failures++;
            $display("FAIL reset_force got=%b exp=110000",
                     {sram_cen, sram_gwen, rd_gnt, wr_gnt, rd_vld, inv_done});
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        cpurst = 1'b0;
        model_reset();
        if (INIT_EN) begin
            for (int i = 0; i <= LAST; i++) begin
                randomize_ports();
                inv_req = $urandom_range(0, 1);
                do_cycle(o, e);
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL init_sweep i=%0d got=%h exp=%h", i, o, e);
                end
            end
            inv_req = 1'b0;
            rd_req  = 1'b0;
            wr_req  = 1'b0;
        end
        do_cycle(o, e);
        checks++;
        if (o !== e || o.ctrl_busy !== 1'b0 || o.inv_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_run got=%h exp=%h", o, e);
        end
    endtask

    task automatic test_read();
        obs_t o, e;
        logic [DW-1:0] q;
        rd_req  = 1'b1;
        wr_req  = 1'b0;
        rd_addr = 10'h155;
        do_cycle(o, e);
        checks++;
        if (o !== e || {o.rd_gnt, o.a, o.cen, o.gwen} !== {1'b1, 10'h155, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL read_grant got=%h exp=%h", o, e);
        end
        rd_req = 1'b0;
        q      = {$urandom, $urandom};
        sram_q = q;
        do_cycle(o, e);
        checks++;
        if (o !== e || o.rd_vld !== 1'b1 || o.rdata !== q) begin
            failures++;
            $display("FAIL read_data got=%h exp=%h", o, e);
        end
    endtask

    task automatic test_starve();
        obs_t o, e;
        bit pattern [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        rd_req = 1'b1;
        wr_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_cycle(o, e);
            checks++;
            if (o !== e || o.wr_gnt !== pattern[i] || o.rd_gnt !== !pattern[i]) begin
                failures++;
                $display("FAIL starve i=%0d wr_gnt=%b rd_gnt=%b exp_wr_gnt=%b", i,
                         o.wr_gnt, o.rd_gnt, pattern[i]);
            end
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        do_cycle(o, e);
    endtask

    task automatic test_write_mask();
        obs_t o, e;
        wr_req  = 1'b1;
        rd_req  = 1'b0;
        wr_addr = AW'($urandom);
        wr_mask = 37'h00_0000_00FF;
        wr_data = 37'h1_2345_6789;
        do_cycle(o, e);
        checks++;
        if (o !== e || o.wen !== 37'h1F_FFFF_FF00 || o.gwen !== 1'b0 || o.d !== 37'h1_2345_6789) begin
            failures++;
            $display("FAIL write_mask got=%h exp=%h", o, e);
        end
        wr_req = 1'b0;
        do_cycle(o, e);
        checks++;
        if (o !== e || o.cen !== 1'b1) begin
            failures++;
            $display("FAIL idle got=%h exp=%h", o, e);
        end
    endtask

    task automatic test_sweep();
        obs_t o, e;
        int pulses;
        randomize_ports();
        wr_req  = 1'b1;
        inv_req = 1'b1;
        do_cycle(o, e);
        checks++;
        if (o !== e || o.wr_gnt !== 1'b1 || o.ctrl_busy !== 1'b0) begin
            failures++;
            $display("FAIL sweep_entry_write got=%h exp=%h", o, e);
        end
        pulses = 0;
        for (int i = 0; i <= LAST + 2; i++) begin
            randomize_ports();
            inv_req = (i == 10);
            do_cycle(o, e);
            pulses += int'(o.inv_done);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL sweep i=%0d got=%h exp=%h", i, o, e);
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL inv_done_pulses got=%0d exp=1", pulses);
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        obs_t o, e;
        inv_req = 1'b1;
        do_cycle(o, e);
        inv_req = 1'b0;
        for (int i = 0; i < 500; i++) begin
            do_cycle(o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL pre_abort i=%0d got=%h exp=%h", i, o, e);
            end
        end
        #1;
        checks++;
        if (sram_a !== 10'd500 || sram_cen !== 1'b0) begin
            failures++;
            $display("FAIL sweep_at_500 a=%0d cen=%b", sram_a, sram_cen);
        end
        cpurst = 1'b1;
        #1;
        checks++;
        if ({sram_cen, sram_gwen, rd_gnt, wr_gnt} !== 4'b1100) begin
            failures++;
            $display("FAIL abort_force got=%b exp=1100", {sram_cen, sram_gwen, rd_gnt, wr_gnt});
        end
        @(negedge clk);
        cpurst = 1'b0;
        model_reset();
        for (int i = 0; i <= (INIT_EN ? LAST + 1 : 1); i++) begin
            do_cycle(o, e);
            checks++;
            if (o !== e || (i == 0 && (o.ctrl_busy !== INIT_EN || o.a !== 10'd0))) begin
                failures++;
                $display("FAIL post_abort i=%0d got=%h exp=%h", i, o, e);
            end
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        for (int i = 0; i < 600; i++) begin
            randomize_ports();
            inv_req = ($urandom_range(0, 199) == 0);
            do_cycle(o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL random i=%0d got=%h exp=%h", i, o, e);
            end
        end
        inv_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read();
        test_starve();
        test_write_mask();
        test_sweep();
        test_reset_mid_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pa_icache_sram_arb.md
PA_ICACHE_SRAM_ARB -- requirements
Module: pa_icache_sram_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, SRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 37, SRAM data and write-mask width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 3, number of consecutive read denials before the read port takes priority.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port forever_cpuclk, input, 1 bit: clock, all state on the rising edge.
REQ-006 SHALL have port cpurst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have ports rd_req (in, 1), rd_addr (in, 10) and rd_gnt (out, 1): fetch read request, address and same-cycle grant.
REQ-008 SHALL have ports rd_vld (out, 1) and rd_data (out, 37): read data valid, and read data equal to sram_q.
REQ-009 SHALL have ports wr_req (in, 1), wr_addr (in, 10), wr_data (in, 37), wr_mask (in, 37, active-high bit enable) and wr_gnt (out, 1): refill write port.
REQ-010 SHALL have ports inv_req (in, 1), inv_done (out, 1, pulse) and ctrl_busy (out, 1): invalidate sweep control.
REQ-011 SHALL have ports sram_a (out, 10), sram_cen (out, 1, active-low), sram_gwen (out, 1, active-low) and sram_wen (out, 37, active-low): SRAM macro controls.
REQ-012 SHALL have ports sram_d (out, 37) and sram_q (in, 37): SRAM macro data.

Function
REQ-013 SHALL implement states INIT, RUN and SWEEP, with a 10-bit sweep counter.
REQ-014 In RUN, SHALL grant wr_req over rd_req, except when the starve counter equals STARVE_LIMIT, in which case rd_req wins.
REQ-015 SHALL assert at most one grant per cycle; grants are combinational and registered nowhere.
REQ-016 On a read grant, SHALL drive sram_cen=0, sram_gwen=1 and sram_a=rd_addr.
REQ-017 On a write grant, SHALL drive sram_cen=0, sram_gwen=0, sram_a=wr_addr, sram_d=wr_data and sram_wen=~wr_mask.
REQ-018 When nothing is granted, SHALL drive sram_cen=1 and sram_gwen=1.
REQ-019 SHALL assert rd_vld exactly one cycle after rd_gnt (1-cycle latency); rd_data is undefined when rd_vld=0.
REQ-020 The starve counter SHALL increment (saturating at STARVE_LIMIT) each RUN cycle with rd_req=1 and rd_gnt=0, and clear on rd_gnt or rd_req=0.
REQ-021 SHALL sample inv_req only in RUN; any rd/wr grant in that same cycle still completes, and SWEEP is entered on the next cycle.
REQ-022 In INIT and SWEEP, SHALL write sram_d=0 with sram_wen=all-0 to address equal to the counter, counter 0 to 1023, one address per cycle.
REQ-023 After the write at address 1023, SHALL return to RUN and clear the counter.
REQ-024 Counter wrap from 1023 to 0 SHALL coincide with the RUN transition.
REQ-025 Leaving SWEEP SHALL pulse inv_done for exactly one cycle, on the first RUN cycle; leaving INIT SHALL NOT pulse inv_done.
REQ-026 In INIT and SWEEP, SHALL hold rd_gnt=0, wr_gnt=0 and ctrl_busy=1; inv_req is ignored; the starve counter holds 0.
REQ-027 In RUN, SHALL drive ctrl_busy=0.

Reset
REQ-028 While cpurst=1, SHALL force sram_cen=1, sram_gwen=1, rd_gnt=0, wr_gnt=0, rd_vld=0 and inv_done=0.
REQ-029 Reset SHALL clear the starve counter and sweep counter to 0.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep; after release, behaviour is per REQ-031/032, with no inv_done.

Configuration
REQ-031 With PA_ICACHE_SRAM_INIT_EN defined, reset SHALL enter INIT: a 1024-cycle zero sweep with ctrl_busy=1, then RUN.
REQ-032 Without PA_ICACHE_SRAM_INIT_EN, reset SHALL enter RUN directly with ctrl_busy=0; SWEEP via inv_req is unaffected.

Verification
REQ-033 Reset release with PA_ICACHE_SRAM_INIT_EN -> 1024 writes of 0 to addresses 0..1023, ctrl_busy=1 for 1024 cycles, no grants, no inv_done.
REQ-034 RUN, rd_req=1 with rd_addr=0x155 -> rd_gnt=1, sram_a=0x155, sram_cen=0, sram_gwen=1; next cycle rd_vld=1 and rd_data=sram_q.
REQ-035 RUN, wr_req and rd_req held high -> wr_gnt for 3 cycles, rd_gnt on cycle 4, then wr_gnt resumes and the starve counter is 0.
REQ-036 RUN, wr_mask=0x0_0000_00FF with wr_data=0x1_2345_6789 -> sram_wen=0x1F_FFFF_FF00, sram_gwen=0, sram_d=0x1_2345_6789.
REQ-037 inv_req=1 together with a write grant -> the write completes, then 1024 sweep cycles, inv_done pulses once, and a second inv_req during the sweep is ignored.
REQ-038 cpurst=1 at sweep address 500 -> sram_cen=1 immediately, and after release the sweep restarts from address 0 (INIT_EN) or the block is in RUN (no INIT_EN).
